// File: rtl/result_collector_if.sv
// Result collector bus: per-core result inputs plus the valid/ready drain port.
// The collector takes the slave side; the producer/consumer environment takes the master side.
interface result_collector_if #(
  parameter int unsigned N_CORES = 23,
  parameter int unsigned DATA_W  = 28,
  parameter int unsigned ID_W    = 5
);
  logic [N_CORES*DATA_W-1:0] core_data;
  logic [N_CORES-1:0]        core_valid;
  logic [DATA_W-1:0]         out_data;
  logic [ID_W-1:0]           out_id;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output core_data, core_valid, out_ready,
    input  out_data, out_id, out_valid
  );

  modport slave (
    input  core_data, core_valid, out_ready,
    output out_data, out_id, out_valid
  );
endinterface

// File: rtl/result_collector.sv
// Result collector: per-core holding registers, round-robin arbiter and a
// first-word-fall-through FIFO tagged with the producing core index.
// Optional feature macro: RESULT_CNT_EN adds result_cnt, a 16-bit count of accepted pops.
module result_collector #(
  parameter int unsigned N_CORES = 23,
  parameter int unsigned DATA_W  = 28,
  parameter int unsigned ID_W    = 5,
  parameter int unsigned DEPTH   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  result_collector_if.slave          bus,
  output logic [N_CORES-1:0]         overrun,
  input  logic                       clr_overrun,
`ifdef RESULT_CNT_EN
  output logic [15:0]                result_cnt,
`endif
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [N_CORES-1:0] hold_v_q, hold_v_d;
  logic [DATA_W-1:0]  hold_data_q [N_CORES];
  logic [DATA_W-1:0]  hold_data_d [N_CORES];
  logic [N_CORES-1:0] overrun_q, overrun_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  entry_t             mem_q [DEPTH];

  logic               pop, push, full, grant_en, grant_vld;
  logic [ID_W-1:0]    grant_idx;
  entry_t             head;

`ifdef RESULT_CNT_EN
  logic [15:0] cnt_q, cnt_d;
`endif

  // FIFO status; a full FIFO may still accept a push when the head leaves this cycle
  always_comb begin
    pop      = (level_q != '0) && bus.out_ready;
    full     = (level_q == LW'(DEPTH));
    grant_en = !full || pop;
  end

  // Round-robin search starting at rr_ptr_q, wrapping mod N_CORES
  always_comb begin
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    sum       = '0;
    idx       = '0;
    if (grant_en) begin
      for (int k = 0; k < int'(N_CORES); k++) begin
        sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
        if (sum >= (ID_W+1)'(N_CORES)) sum = sum - (ID_W+1)'(N_CORES);
        idx = sum[ID_W-1:0];
        if (!grant_vld && hold_v_q[idx]) begin
          grant_vld = 1'b1;
          grant_idx = idx;
        end
      end
    end
    push = grant_vld;
  end

  // Holding stage and overrun flags; a set in the same cycle beats the clear
  always_comb begin
    logic granted;
    hold_v_d    = hold_v_q;
    hold_data_d = hold_data_q;
    overrun_d   = clr_overrun ? '0 : overrun_q;
    granted     = 1'b0;
    for (int i = 0; i < int'(N_CORES); i++) begin
      granted = grant_vld && (grant_idx == ID_W'(i));
      if (bus.core_valid[i]) begin
        if (!hold_v_q[i] || granted) begin
          hold_data_d[i] = bus.core_data[i*DATA_W +: DATA_W];
          hold_v_d[i]    = 1'b1;
        end else begin
          overrun_d[i] = 1'b1;
        end
      end else if (granted) begin
        hold_v_d[i] = 1'b0;
      end
    end
  end

  // Pointer, level and arbiter pointer next-state
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    rr_ptr_d = rr_ptr_q;
    if (grant_vld) begin
      rr_ptr_d = (grant_idx == ID_W'(N_CORES - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

`ifdef RESULT_CNT_EN
  // Pop counter; a clear together with a pop leaves exactly one
  always_comb begin
    cnt_d = clr_overrun ? '0 : cnt_q;
    if (pop) cnt_d = cnt_d + 16'd1;
  end

  // Pop counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign result_cnt = cnt_q;
`endif

  // Control state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_v_q    <= '0;
      hold_data_q <= '{default: '0};
      overrun_q   <= '0;
      rr_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
    end else begin
      hold_v_q    <= hold_v_d;
      hold_data_q <= hold_data_d;
      overrun_q   <= overrun_d;
      rr_ptr_q    <= rr_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
    end
  end

  // FIFO storage; contents are only visible while level is non-zero, so no reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{id: grant_idx, data: hold_data_q[grant_idx]};
  end

  // Head presentation, forced to zero while empty
  always_comb begin
    head          = mem_q[rd_ptr_q];
    bus.out_valid = (level_q != '0);
    bus.out_data  = bus.out_valid ? head.data : '0;
    bus.out_id    = bus.out_valid ? head.id : '0;
  end

  assign overrun    = overrun_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_result_collector.sv
// Self-checking bench for result_collector: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_result_collector;
  localparam int N_CORES = 23;
  localparam int DATA_W  = 28;
  localparam int ID_W    = 5;
  localparam int DEPTH   = 16;
  localparam int LW      = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               rst;
  logic [N_CORES-1:0] overrun;
  logic               clr_overrun;
  logic [LW-1:0]      fifo_level;
`ifdef RESULT_CNT_EN
  logic [15:0]        result_cnt;
`endif

  result_collector_if #(.N_CORES(N_CORES), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

  result_collector #(.N_CORES(N_CORES), .DATA_W(DATA_W), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .overrun     (overrun),
    .clr_overrun (clr_overrun),
`ifdef RESULT_CNT_EN
    .result_cnt  (result_cnt),
`endif
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Reference model state
  entry_t             q[$];
  bit                 m_hv[N_CORES];
  logic [DATA_W-1:0]  m_hd[N_CORES];
  int                 m_rr;
  logic [N_CORES-1:0] m_ovr;
  logic [15:0]        m_cnt;

  int total = 0;
  int bad   = 0;

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < N_CORES; i++) begin
      m_hv[i] = 1'b0;
      m_hd[i] = '0;
    end
    m_rr  = 0;
    m_ovr = '0;
    m_cnt = '0;
  endtask

  // Advance the model by one clock using the inputs currently driven
  task automatic model_step();
    bit     pop, gv;
    int     g;
    entry_t e;
    pop = (q.size() != 0) && bus.out_ready;
    gv  = 1'b0;
    g   = 0;
    if (q.size() < DEPTH || pop) begin
      for (int k = 0; k < N_CORES; k++) begin
        if (!gv && m_hv[(m_rr + k) % N_CORES]) begin
          gv = 1'b1;
          g  = (m_rr + k) % N_CORES;
        end
      end
    end
    if (pop) void'(q.pop_front());
    if (gv) begin
      e.id   = g[ID_W-1:0];
      e.data = m_hd[g];
      q.push_back(e);
      m_rr = (g + 1) % N_CORES;
    end
    if (clr_overrun) begin
      m_ovr = '0;
      m_cnt = '0;
    end
    if (pop) m_cnt = m_cnt + 16'd1;
    for (int i = 0; i < N_CORES; i++) begin
      if (bus.core_valid[i]) begin
        if (!m_hv[i] || (gv && g == i)) begin
          m_hd[i] = bus.core_data[i*DATA_W +: DATA_W];
          m_hv[i] = 1'b1;
        end else begin
          m_ovr[i] = 1'b1;
        end
      end else if (gv && g == i) begin
        m_hv[i] = 1'b0;
      end
    end
  endtask

  function automatic logic exp_valid();
    return q.size() != 0;
  endfunction

  function automatic logic [DATA_W-1:0] exp_data();
    return (q.size() != 0) ? q[0].data : '0;
  endfunction

  function automatic logic [ID_W-1:0] exp_id();
    return (q.size() != 0) ? q[0].id : '0;
  endfunction

  function automatic logic [LW-1:0] exp_level();
    return LW'(q.size());
  endfunction

  function automatic logic [DATA_W-1:0] rand_data();
    logic [31:0] r;
    r = $urandom();
    return r[DATA_W-1:0];
  endfunction

  // DEPTH cores, skipping 2 and 7 which the directed tests use on their own
  function automatic logic [N_CORES-1:0] fill_mask();
    logic [N_CORES-1:0] m;
    int                 n;
    m = '0;
    n = 0;
    for (int i = 0; i < N_CORES; i++) begin
      if (i != 2 && i != 7 && n < DEPTH) begin
        m[i] = 1'b1;
        n++;
      end
    end
    return m;
  endfunction

  // One clock: model follows the driven inputs; sampling happens 1 time unit after the edge
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_core(input int i, input logic [DATA_W-1:0] d);
    bus.core_data[i*DATA_W +: DATA_W] = d;
    bus.core_valid[i] = 1'b1;
  endtask

  task automatic idle_inputs();
    bus.core_valid = '0;
    bus.core_data  = '0;
    bus.out_ready  = 1'b0;
    clr_overrun    = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_fifo();
    logic [N_CORES-1:0] m;
    m = fill_mask();
    for (int i = 0; i < N_CORES; i++) if (m[i]) pulse_core(i, rand_data());
    step();
    bus.core_valid = '0;
    repeat (DEPTH) step();
    total++;
    if (fifo_level !== LW'(DEPTH)) begin
      bad++;
      $display("FAIL fill_level got=%0d want=%0d", fifo_level, DEPTH);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_id !== '0) begin
      bad++;
      $display("FAIL reset_out got v=%0b d=%h id=%0d want 0/0/0",
               bus.out_valid, bus.out_data, bus.out_id);
    end
    total++;
    if (fifo_level !== '0 || overrun !== '0) begin
      bad++;
      $display("FAIL reset_state got level=%0d ovr=%h want 0/0", fifo_level, overrun);
    end
`ifdef RESULT_CNT_EN
    total++;
    if (result_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_cnt got=%0d want=0", result_cnt);
    end
`endif
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    bus.out_ready = 1'b1;
    pulse_core(3, 28'h0ABCDEF);
    step();
    bus.core_valid = '0;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_early got v=%0b want=0", bus.out_valid);
    end
    step();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 28'h0ABCDEF || bus.out_id !== 5'd3) begin
      bad++;
      $display("FAIL single_head got v=%0b d=%h id=%0d want 1/0abcdef/3",
               bus.out_valid, bus.out_data, bus.out_id);
    end
    step();
    total++;
    if (fifo_level !== '0 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_drain got level=%0d v=%0b want 0/0", fifo_level, bus.out_valid);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    pulse_core(0, 28'h0000010);
    pulse_core(5, 28'h0000050);
    pulse_core(22, 28'hFFFFFFF);
    step();
    bus.core_valid = '0;
    repeat (3) step();
    total++;
    if (fifo_level !== LW'(3) || overrun !== '0) begin
      bad++;
      $display("FAIL simul_level got level=%0d ovr=%h want 3/0", fifo_level, overrun);
    end
    total++;
    if (bus.out_id !== 5'd0 || bus.out_data !== 28'h0000010) begin
      bad++;
      $display("FAIL simul_head got id=%0d d=%h want 0/0000010", bus.out_id, bus.out_data);
    end
  endtask

  task automatic test_round_robin();
    logic [ID_W-1:0] want_ids [5];
    int              got;
    want_ids = '{5'd0, 5'd5, 5'd22, 5'd1, 5'd22};
    pulse_core(22, 28'h2222222);
    pulse_core(1, 28'h1111111);
    step();
    bus.core_valid = '0;
    repeat (2) step();
    total++;
    if (fifo_level !== LW'(5)) begin
      bad++;
      $display("FAIL rr_level got=%0d want=5", fifo_level);
    end
    bus.out_ready = 1'b1;
    got = 0;
    for (int n = 0; n < 10 && bus.out_valid; n++) begin
      if (got < 5) begin
        total++;
        if (bus.out_id !== want_ids[got] || bus.out_data !== exp_data()) begin
          bad++;
          $display("FAIL rr_order[%0d] got id=%0d d=%h want id=%0d d=%h",
                   got, bus.out_id, bus.out_data, want_ids[got], exp_data());
        end
      end
      got++;
      step();
    end
    total++;
    if (got != 5) begin
      bad++;
      $display("FAIL rr_count got=%0d want=5", got);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_overrun();
    bit              seen;
    logic [DATA_W-1:0] got;
    apply_reset();
    fill_fifo();
    pulse_core(7, 28'h0000001);
    step();
    pulse_core(7, 28'h0000002);
    step();
    bus.core_valid = '0;
    total++;
    if (overrun !== (N_CORES'(1) << 7)) begin
      bad++;
      $display("FAIL ovr_set got=%h want=%h", overrun, N_CORES'(1) << 7);
    end
    bus.out_ready = 1'b1;
    seen = 1'b0;
    got  = '0;
    for (int n = 0; n < 3 * DEPTH && bus.out_valid; n++) begin
      if (!seen && bus.out_id == 5'd7) begin
        seen = 1'b1;
        got  = bus.out_data;
      end
      step();
    end
    total++;
    if (!seen || got !== 28'h0000001) begin
      bad++;
      $display("FAIL ovr_data got seen=%0b d=%h want 1/0000001", seen, got);
    end
    total++;
    if (overrun !== m_ovr || fifo_level !== '0) begin
      bad++;
      $display("FAIL ovr_sticky got ovr=%h lvl=%0d want ovr=%h lvl=0", overrun, fifo_level, m_ovr);
    end
    bus.out_ready = 1'b0;
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    total++;
    if (overrun !== '0) begin
      bad++;
      $display("FAIL ovr_clear got=%h want=0", overrun);
    end
  endtask

  task automatic test_full_push_pop();
    logic [ID_W-1:0]   last_id;
    logic [DATA_W-1:0] last_data;
    apply_reset();
    fill_fifo();
    pulse_core(2, 28'h5A5A5A5);
    step();
    bus.core_valid = '0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    total++;
    if (fifo_level !== LW'(DEPTH)) begin
      bad++;
      $display("FAIL full_pp_level got=%0d want=%0d", fifo_level, DEPTH);
    end
    bus.out_ready = 1'b1;
    last_id   = '0;
    last_data = '0;
    for (int n = 0; n < 2 * DEPTH && bus.out_valid; n++) begin
      total++;
      if (bus.out_id !== exp_id() || bus.out_data !== exp_data()) begin
        bad++;
        $display("FAIL full_pp_head got id=%0d d=%h want id=%0d d=%h",
                 bus.out_id, bus.out_data, exp_id(), exp_data());
      end
      last_id   = bus.out_id;
      last_data = bus.out_data;
      step();
    end
    total++;
    if (last_id !== 5'd2 || last_data !== 28'h5A5A5A5) begin
      bad++;
      $display("FAIL full_pp_tail got id=%0d d=%h want 2/5a5a5a5", last_id, last_data);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bus.core_valid = '0;
      for (int i = 0; i < N_CORES; i++) begin
        if ($urandom_range(0, 9) == 0) pulse_core(i, rand_data());
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      clr_overrun   = ($urandom_range(0, 15) == 0);
      step();
      total++;
      if (bus.out_valid !== exp_valid() || bus.out_id !== exp_id()
          || bus.out_data !== exp_data()) begin
        bad++;
        $display("FAIL rand_head c=%0d got v=%0b id=%0d d=%h want v=%0b id=%0d d=%h", c,
                 bus.out_valid, bus.out_id, bus.out_data, exp_valid(), exp_id(), exp_data());
      end
      total++;
      if (fifo_level !== exp_level() || overrun !== m_ovr) begin
        bad++;
        $display("FAIL rand_state c=%0d got lvl=%0d ovr=%h want lvl=%0d ovr=%h", c,
                 fifo_level, overrun, exp_level(), m_ovr);
      end
`ifdef RESULT_CNT_EN
      total++;
      if (result_cnt !== m_cnt) begin
        bad++;
        $display("FAIL rand_cnt c=%0d got=%0d want=%0d", c, result_cnt, m_cnt);
      end
`endif
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    apply_reset();
    pulse_core(1, rand_data());
    pulse_core(4, rand_data());
    pulse_core(9, rand_data());
    pulse_core(13, rand_data());
    pulse_core(20, rand_data());
    step();
    bus.core_valid = '0;
    repeat (5) step();
    total++;
    if (fifo_level !== LW'(5)) begin
      bad++;
      $display("FAIL arst_pre got=%0d want=5", fifo_level);
    end
    #3 rst = 1'b0;
    #1;
    model_reset();
    total++;
    if (bus.out_valid !== 1'b0 || fifo_level !== '0) begin
      bad++;
      $display("FAIL arst_now got v=%0b lvl=%0d want 0/0", bus.out_valid, fifo_level);
    end
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    repeat (4) begin
      step();
      total++;
      if (bus.out_valid !== exp_valid() || fifo_level !== exp_level()) begin
        bad++;
        $display("FAIL arst_after got v=%0b lvl=%0d want 0/0", bus.out_valid, fifo_level);
      end
    end
`ifdef RESULT_CNT_EN
    total++;
    if (result_cnt !== 16'd0) begin
      bad++;
      $display("FAIL arst_cnt got=%0d want=0", result_cnt);
    end
`endif
    bus.out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_round_robin();
    test_overrun();
    test_full_push_pop();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
